// File: rtl/ram_access_ctrl_pkg.sv
// ram_ctrl_pkg: shared types and widths for the data-RAM access controller.
//   owner_t     : who drives the RAM in the current cycle.
//   next_owner(): fixed-priority arbitration with a starvation override.
package ram_ctrl_pkg;

  localparam int RAM_AW  = 8;   // RAM byte address width
  localparam int RAM_DW  = 8;   // RAM read data width
  localparam int RAM_WW  = 32;  // RAM write data width
  localparam int DISP_IW = 7;   // shadow-buffer index width

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_SCAN = 2'd2
  } owner_t;

  // A starved scanner beats the CPU; otherwise the CPU has priority.
  function automatic owner_t next_owner(input logic scan_pend,
                                        input logic starved,
                                        input logic cpu_ok);
    if (scan_pend && starved) return OWN_SCAN;
    if (cpu_ok)               return OWN_CPU;
    if (scan_pend)            return OWN_SCAN;
    return OWN_IDLE;
  endfunction

endpackage

// File: rtl/ram_access_ctrl_disp_scanner.sv
// disp_scanner: index counter and done pulse for the display copy.
//   i_scan_start : pulse, starts a copy when idle (or on the final byte).
//   i_grant      : the scanner owns the RAM this cycle.
//   o_busy       : copy in progress.
//   o_pend       : scanner wants the RAM at the next arbitration edge.
//   o_idx        : current byte index within the phrase.
//   o_done       : one-cycle pulse after the last byte was copied.
module disp_scanner
  import ram_ctrl_pkg::*;
#(
  parameter int DISP_LEN = 65
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              i_scan_start,
  input  logic              i_grant,
  output logic              o_busy,
  output logic              o_pend,
  output logic [RAM_AW-1:0] o_idx,
  output logic              o_done
);

  localparam logic [RAM_AW-1:0] LAST = RAM_AW'(DISP_LEN - 1);

  logic              r_busy;
  logic              r_done;
  logic [RAM_AW-1:0] r_idx;
  logic              w_fin;

  // Final byte is being read this cycle.
  assign w_fin = r_busy & i_grant & (r_idx == LAST);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_idx  <= '0;
    end else begin
      r_done <= w_fin;
      if (w_fin) begin
        // A start arriving with the last byte chains straight into a new copy.
        r_idx  <= '0;
        r_busy <= i_scan_start;
      end else if (!r_busy) begin
        if (i_scan_start) begin
          r_busy <= 1'b1;
          r_idx  <= '0;
        end
      end else if (i_grant) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign o_busy = r_busy;
  // The finishing copy must not win the edge that ends it.
  assign o_pend = r_busy & ~w_fin;
  assign o_idx  = r_idx;
  assign o_done = r_done;

endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: shares the single-port data RAM between the CPU
// load/store port (req/ack) and the display scanner.
//   clock, rst_n              : clock, async active-low reset
//   cpu_req/we/addr/wdata     : CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata        : one-cycle ack, read byte in that cycle
//   scan_start/busy/done      : display copy control/status
//   disp_we/idx/byte          : shadow-buffer write port
//   ram_address/data/wren/q   : RAM port (q is combinational)
// Each owner holds the RAM for one cycle; outputs are muxed from the
// registered owner so the RAM read data lands in the same cycle.
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DISP_BASE  = 0,
  parameter int DISP_LEN   = 65,
  parameter int STARVE_MAX = 4
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [RAM_AW-1:0]  cpu_addr,
  input  logic [RAM_WW-1:0]  cpu_wdata,
  output logic               cpu_ack,
  output logic [RAM_DW-1:0]  cpu_rdata,
  input  logic               scan_start,
  output logic               scan_busy,
  output logic               scan_done,
  output logic               disp_we,
  output logic [DISP_IW-1:0] disp_idx,
  output logic [RAM_DW-1:0]  disp_byte,
  output logic [RAM_AW-1:0]  ram_address,
  output logic [RAM_WW-1:0]  ram_data,
  output logic               ram_wren,
  input  logic [RAM_DW-1:0]  ram_q
);

  localparam int                SCW  = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0]    SMAX = SCW'(STARVE_MAX);
  localparam logic [RAM_AW-1:0] BASE = RAM_AW'(DISP_BASE);

  owner_t            r_owner;
  logic              r_cooldown;
  logic [SCW-1:0]    r_starve;
  owner_t            w_next;
  logic              w_pend;
  logic              w_busy;
  logic              w_done;
  logic [RAM_AW-1:0] w_idx;

  disp_scanner #(.DISP_LEN(DISP_LEN)) u_scan (
    .clock        (clock),
    .rst_n        (rst_n),
    .i_scan_start (scan_start),
    .i_grant      (r_owner == OWN_SCAN),
    .o_busy       (w_busy),
    .o_pend       (w_pend),
    .o_idx        (w_idx),
    .o_done       (w_done)
  );

  assign w_next = next_owner(w_pend, r_starve == SMAX, cpu_req & ~r_cooldown);

  // r_cooldown is high during the CPU grant cycle, so the edge that ends
  // it ignores the still-held req and cannot grant the same access twice.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_owner    <= OWN_IDLE;
      r_cooldown <= 1'b0;
      r_starve   <= '0;
    end else begin
      r_owner    <= w_next;
      r_cooldown <= (w_next == OWN_CPU);
      if (!w_pend || w_next == OWN_SCAN)
        r_starve <= '0;
      else if (r_starve != SMAX)
        r_starve <= r_starve + 1'b1;
    end
  end

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    cpu_ack     = 1'b0;
    cpu_rdata   = '0;
    disp_we     = 1'b0;
    disp_idx    = '0;
    disp_byte   = '0;
    case (r_owner)
      OWN_CPU: begin
        ram_address = cpu_addr;
        ram_data    = cpu_wdata;
        ram_wren    = cpu_we;
        cpu_ack     = 1'b1;
        cpu_rdata   = ram_q;
      end
      OWN_SCAN: begin
        ram_address = BASE + w_idx;  // wraps modulo 256
        disp_we     = 1'b1;
        disp_idx    = w_idx[DISP_IW-1:0];
        disp_byte   = ram_q;
      end
      default: ;
    endcase
  end

  assign scan_busy = w_busy;
  assign scan_done = w_done;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: stimulus pushes expected CPU and
// display transactions; negedge monitors pop and compare.
module tb_ram_access_ctrl;
  import ram_ctrl_pkg::*;

  localparam int LEN_A = 65;
  localparam int SMAX  = 4;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  // DUT A: base 0, length 65
  logic        a_cpu_req = 0, a_cpu_we = 0, a_scan_start = 0;
  logic [7:0]  a_cpu_addr = 0;
  logic [31:0] a_cpu_wdata = 0;
  logic        a_cpu_ack, a_scan_busy, a_scan_done, a_disp_we, a_ram_wren;
  logic [7:0]  a_cpu_rdata, a_disp_byte, a_ram_address, a_ram_q;
  logic [6:0]  a_disp_idx;
  logic [31:0] a_ram_data;

  // DUT B: base 250, length 10 (wrap)
  logic        b_cpu_req = 0, b_cpu_we = 0, b_scan_start = 0;
  logic [7:0]  b_cpu_addr = 0;
  logic [31:0] b_cpu_wdata = 0;
  logic        b_cpu_ack, b_scan_busy, b_scan_done, b_disp_we, b_ram_wren;
  logic [7:0]  b_cpu_rdata, b_disp_byte, b_ram_address, b_ram_q;
  logic [6:0]  b_disp_idx;
  logic [31:0] b_ram_data;

  ram_access_ctrl #(.DISP_BASE(0), .DISP_LEN(LEN_A), .STARVE_MAX(SMAX)) dut_a (
    .clock(clock), .rst_n(rst_n),
    .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
    .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
    .scan_start(a_scan_start), .scan_busy(a_scan_busy), .scan_done(a_scan_done),
    .disp_we(a_disp_we), .disp_idx(a_disp_idx), .disp_byte(a_disp_byte),
    .ram_address(a_ram_address), .ram_data(a_ram_data), .ram_wren(a_ram_wren), .ram_q(a_ram_q)
  );

  ram_access_ctrl #(.DISP_BASE(250), .DISP_LEN(10), .STARVE_MAX(SMAX)) dut_b (
    .clock(clock), .rst_n(rst_n),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .scan_start(b_scan_start), .scan_busy(b_scan_busy), .scan_done(b_scan_done),
    .disp_we(b_disp_we), .disp_idx(b_disp_idx), .disp_byte(b_disp_byte),
    .ram_address(b_ram_address), .ram_data(b_ram_data), .ram_wren(b_ram_wren), .ram_q(b_ram_q)
  );

  // RAM contents pattern: (a*4+1) mod 256, so RAM[0x10] = 0x41.
  function automatic logic [7:0] pat(input logic [7:0] a);
    return {a[5:0], 2'b01};
  endfunction

  logic       ld = 1'b1;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  assign a_ram_q = mem_a[a_ram_address];
  assign b_ram_q = mem_b[b_ram_address];

  always @(posedge clock) begin
    if (ld) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= pat(8'(i));
    end else if (a_ram_wren) begin
      mem_a[a_ram_address] <= a_ram_data[7:0];
    end
  end

  always @(posedge clock) begin
    if (ld) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= pat(8'(i));
    end else if (b_ram_wren) begin
      mem_b[b_ram_address] <= b_ram_data[7:0];
    end
  end

  typedef struct { logic we; logic [7:0] addr; logic [31:0] wdata; logic [7:0] rdata; } cpu_exp_t;
  typedef struct { logic [6:0] idx; logic [7:0] addr; logic [7:0] data; } disp_exp_t;

  cpu_exp_t  cpu_q[$];
  disp_exp_t disp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  int done_cnt = 0;
  int gap_lim  = 0;
  int kb       = 0;
  int b_done   = 0;
  logic stop   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---- monitor for DUT A ----
  logic prev_last = 0;
  int   gap       = 0;
  logic gap_ok    = 0;
  always @(negedge clock) begin
    cpu_exp_t  ce;
    disp_exp_t de;
    if (!rst_n) begin
      prev_last = 0;
      gap_ok    = 0;
    end else begin
      if (a_cpu_ack && a_disp_we) chk("a_exclusive", 1, 0);
      if (a_cpu_ack) begin
        ack_cnt++;
        if (cpu_q.size() == 0) chk("a_unexpected_ack", 1, 0);
        else begin
          ce = cpu_q.pop_front();
          chk("cpu_addr", a_ram_address, ce.addr);
          chk("cpu_wren", a_ram_wren, ce.we);
          if (ce.we) chk("cpu_wdata", a_ram_data, ce.wdata);
          else       chk("cpu_rdata", a_cpu_rdata, ce.rdata);
        end
      end else if (a_ram_wren) begin
        chk("wren_without_ack", 1, 0);
      end
      if (!a_scan_busy && !a_disp_we) gap_ok = 0;
      if (a_disp_we) begin
        if (gap_ok) chk("scan_gap_le_lim", gap <= gap_lim, 1);
        gap = 0;
        gap_ok = 1;
        if (disp_q.size() == 0) chk("a_unexpected_disp_we", 1, 0);
        else begin
          de = disp_q.pop_front();
          chk("disp_idx", a_disp_idx, de.idx);
          chk("disp_addr", a_ram_address, de.addr);
          chk("disp_byte", a_disp_byte, de.data);
        end
      end else begin
        gap++;
      end
      if (a_scan_done || prev_last) chk("scan_done_timing", a_scan_done, prev_last);
      if (a_scan_done) done_cnt++;
      prev_last = a_disp_we && (a_disp_idx == 7'(LEN_A - 1));
    end
  end

  // ---- monitor for DUT B (wrap) ----
  logic [7:0] wrap_addr [10] = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254,
                                 8'd255, 8'd0, 8'd1, 8'd2, 8'd3};
  always @(negedge clock) begin
    if (rst_n) begin
      if (b_cpu_ack) chk("b_unexpected_ack", 1, 0);
      if (b_disp_we) begin
        if (kb >= 10) chk("b_extra_disp_we", 1, 0);
        else begin
          chk("wrap_addr", b_ram_address, wrap_addr[kb]);
          chk("wrap_idx", b_disp_idx, 7'(kb));
          chk("wrap_byte", b_disp_byte, pat(wrap_addr[kb]));
        end
        kb++;
      end
      if (b_scan_done) b_done++;
    end
  end

  // ---- stimulus helpers ----
  task automatic wait_ack(output int n, output logic ok);
    n = 0; ok = 0;
    while (!ok && n <= 40) begin
      @(negedge clock);
      if (a_cpu_ack) ok = 1;
      else n++;
    end
    if (!ok) chk("ack_timeout", 0, 1);
  endtask

  task automatic cpu_access(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                            input logic [7:0] rd, output int lat, output int ack_cyc);
    logic ok;
    cpu_q.push_back('{we, addr, wd, rd});
    @(posedge clock); #1;
    a_cpu_req = 1; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wd;
    wait_ack(lat, ok);
    ack_cyc = cyc;
    @(posedge clock); #1;
    a_cpu_req = 0; a_cpu_we = 0;
  endtask

  task automatic push_scan_a();
    for (int i = 0; i < LEN_A; i++) disp_q.push_back('{7'(i), 8'(i), pat(8'(i))});
  endtask

  task automatic pulse_start_a();
    @(posedge clock); #1 a_scan_start = 1;
    @(posedge clock); #1 a_scan_start = 0;
  endtask

  task automatic wait_done_a(input int bound);
    int n;
    logic seen;
    n = 0; seen = 0;
    while (!seen && n < bound) begin
      @(negedge clock);
      if (a_scan_done) seen = 1;
      n++;
    end
    if (!seen) chk("scan_done_timeout", 0, 1);
  endtask

  // CPU hammers the RAM with reads while one scan runs to completion.
  task automatic contention(input logic [7:0] abase);
    stop = 0;
    fork
      begin
        logic [7:0] addr;
        logic ok, running;
        int n;
        addr = abase;
        cpu_q.push_back('{1'b0, addr, 32'h0, pat(addr)});
        @(posedge clock); #1;
        a_cpu_req = 1; a_cpu_we = 0; a_cpu_addr = addr;
        running = 1;
        while (running) begin
          wait_ack(n, ok);
          if (stop || !ok) begin
            a_cpu_req = 0;  // dropped mid-cycle, before the next sampling edge
            running = 0;
          end else begin
            @(posedge clock); #1;
            addr = addr + 8'd1;
            a_cpu_addr = addr;
            cpu_q.push_back('{1'b0, addr, 32'h0, pat(addr)});
          end
        end
      end
      begin
        repeat (3) @(posedge clock);
        push_scan_a();
        pulse_start_a();
        wait_done_a(1000);
        stop = 1;
      end
    join
  endtask

  // ---- main sequence ----
  initial begin
    int lat, c1, c2, a0, n;
    logic hit;

    repeat (3) @(posedge clock);
    #1 ld = 0;
    @(negedge clock) rst_n = 1;

    // reset state
    @(negedge clock);
    chk("rst_cpu_ack", a_cpu_ack, 0);
    chk("rst_scan_busy", a_scan_busy, 0);
    chk("rst_disp_we", a_disp_we, 0);
    chk("rst_ram_bus", {a_ram_address, a_ram_wren, a_ram_data}, 0);

    // 1: CPU read, one-cycle latency, no double grant
    cpu_access(0, 8'h10, 32'h0, 8'h41, lat, c1);
    chk("t1_latency", lat, 1);
    a0 = ack_cnt;
    repeat (6) @(posedge clock);
    chk("t1_no_second_ack", ack_cnt - a0, 0);

    // 2: write 0xAB to 0x05, read it back
    cpu_access(1, 8'h05, 32'h0000_00AB, 8'h00, lat, c1);
    chk("t2_wr_latency", lat, 1);
    cpu_access(0, 8'h05, 32'h0, 8'hAB, lat, c2);
    chk("t2_ack_spacing_ge2", (c2 - c1) >= 2, 1);

    // restore the pattern for the scan tests
    @(posedge clock); #1 ld = 1;
    @(posedge clock); #1 ld = 0;

    // 3: full scan, stray starts while busy are ignored
    gap_lim = 0;
    push_scan_a();
    pulse_start_a();
    repeat (12) @(posedge clock);
    chk("t3_busy", a_scan_busy, 1);
    pulse_start_a();
    repeat (25) @(posedge clock);
    pulse_start_a();
    wait_done_a(300);
    repeat (4) @(posedge clock);
    chk("t3_idle_after", a_scan_busy, 0);

    // 4a: contention with cooldown -> strict alternation
    gap_lim = 1;
    contention(8'h80);
    repeat (4) @(posedge clock);

    // 4b: cooldown disabled -> starvation limit still guarantees progress
    gap_lim = SMAX;
    force dut_a.r_cooldown = 1'b0;
    contention(8'hC0);
    release dut_a.r_cooldown;
    repeat (4) @(posedge clock);

    // 5: wrap on DUT B
    @(posedge clock); #1 b_scan_start = 1;
    @(posedge clock); #1 b_scan_start = 0;
    n = 0;
    while (b_done == 0 && n < 100) begin @(negedge clock); n++; end
    repeat (3) @(posedge clock);
    chk("t5_wrap_count", kb, 10);
    chk("t5_done_once", b_done, 1);

    // 6: reset mid-scan
    gap_lim = 0;
    push_scan_a();
    pulse_start_a();
    n = 0; hit = 0;
    while (!hit && n < 200) begin
      @(negedge clock);
      if (a_disp_we && a_disp_idx == 7'd20) hit = 1;
      n++;
    end
    chk("t6_reached_idx20", hit, 1);
    #2 rst_n = 0;
    #1;
    chk("t6_rst_busy", a_scan_busy, 0);
    chk("t6_rst_disp", {a_disp_we, a_disp_idx, a_disp_byte}, 0);
    chk("t6_rst_ram", {a_ram_address, a_ram_wren, a_ram_data}, 0);
    chk("t6_rst_cpu", {a_cpu_ack, a_cpu_rdata, a_scan_done}, 0);
    disp_q.delete();
    a0 = done_cnt;
    repeat (3) @(posedge clock);
    @(negedge clock) rst_n = 1;
    repeat (5) @(posedge clock);
    chk("t6_no_done", done_cnt - a0, 0);
    push_scan_a();
    pulse_start_a();
    wait_done_a(300);
    repeat (4) @(posedge clock);

    // leftovers
    chk("end_cpu_q_empty", cpu_q.size(), 0);
    chk("end_disp_q_empty", disp_q.size(), 0);
    chk("end_done_count", done_cnt, 4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
